opimm_decode_stage: RTL

- Pipelined decode stage that takes raw 32-bit RV32I instruction words and produces the operand/control fields the OP-IMM ALU consumes: funct3, bit_th, the sign-extended immediate, and register indices.
- Sits between instruction fetch and the ALU/regfile-read stage.
- Uses a valid/ready handshake on both sides and a 2-entry skid buffer, so in_ready is a registered signal.
- Flags illegal OP-IMM encodings and keeps decode statistics.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/opimm_decode_stage_if.sv | 31 +++
 rtl/opimm_field_decode.sv | 51 +++++
 rtl/opimm_decode_stage.sv | 88 ++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions.
// OP-IMM opcode, funct3/funct7 codes and the decoded bundle.
package rv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        bit_th;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        illegal;
  } opimm_dec_t;

endpackage

// File: rtl/opimm_decode_stage_if.sv
// Fetch-side and ALU-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface opimm_decode_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  funct3;
  logic        bit_th;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic        illegal;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid,
    input  funct3, bit_th, imm,
    input  rs1, rd, illegal
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid,
    output funct3, bit_th, imm,
    output rs1, rd, illegal
  );

endinterface

// File: rtl/opimm_field_decode.sv
// Combinational OP-IMM field decoder.
// Shared with the fetch-side predecoder.
module opimm_field_decode
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output opimm_dec_t  dec
);

  logic [6:0]  f7;
  logic [31:0] shamt;
  logic [31:0] sext;
  logic        is_sll;
  logic        is_srx;
  logic        bad_f7;

  assign f7    = inst[31:25];
  assign shamt = {27'b0, inst[24:20]};
  assign sext  = {{20{inst[31]}}, inst[31:20]};

  // Field extraction, shift immediates and legality.
  always_comb begin
    dec        = '0;
    bad_f7     = 1'b0;
    is_sll     = inst[14:12] == F3_SLLI;
    is_srx     = inst[14:12] == F3_SRXI;
    dec.funct3 = inst[14:12];
    dec.bit_th = ~inst[30];
    dec.rs1    = inst[19:15];
    dec.rd     = inst[11:7];
    dec.imm    = sext;
    unique case (1'b1)
      is_sll: begin
        dec.imm = shamt;
        bad_f7  = f7 != FUNCT7_ZERO;
      end
      is_srx: begin
        dec.imm = shamt;
        bad_f7  = (f7 != FUNCT7_ZERO)
                & (f7 != FUNCT7_SRA);
      end
      default: begin
        dec.imm = sext;
        bad_f7  = 1'b0;
      end
    endcase
    dec.illegal = (inst[6:0] != OPC_OP_IMM)
                | bad_f7;
  end

endmodule

// File: rtl/opimm_decode_stage.sv
// OP-IMM decode stage with output + skid register.
// in_ready comes straight from the skid valid flop.
module opimm_decode_stage
  import rv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  opimm_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  opimm_dec_t dec;
  opimm_dec_t or_q;
  opimm_dec_t sk_q;
  logic       or_v;
  logic       sk_v;
  logic       in_fire;
  logic       out_fire;
  logic       or_free;

  opimm_field_decode u_dec (
    .inst (bus.inst),
    .dec  (dec)
  );

  assign in_fire  = bus.in_valid & ~sk_v;
  assign out_fire = or_v & bus.out_ready;
  assign or_free  = ~or_v | bus.out_ready;

  assign bus.in_ready  = ~sk_v;
  assign bus.out_valid = or_v;
  assign bus.funct3    = or_q.funct3;
  assign bus.bit_th    = or_q.bit_th;
  assign bus.imm       = or_q.imm;
  assign bus.rs1       = or_q.rs1;
  assign bus.rd        = or_q.rd;
  assign bus.illegal   = or_q.illegal;

  // Output/skid register movement; skid refills OR first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_q <= '0;
      sk_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
    end else if (or_free) begin
      if (sk_v) begin
        or_q <= sk_q;
        or_v <= 1'b1;
        sk_v <= 1'b0;
      end else if (in_fire) begin
        or_q <= dec;
        or_v <= 1'b1;
      end else begin
        or_v <= 1'b0;
      end
    end else if (in_fire) begin
      sk_q <= dec;
      sk_v <= 1'b1;
    end
  end

  // Statistics on each instruction taken downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_count <= '0;
      illegal_count <= '0;
    end else if (out_fire) begin
      if (or_q.illegal) begin
        if (illegal_count != '1)
          illegal_count <= illegal_count + CNT_ONE;
      end else begin
        decoded_count <= decoded_count + CNT_ONE;
      end
    end
  end

endmodule
